// File: rtl/csoc_test_top.sv
// csoc_test_top: FPGA-side harness bridging a host 8N1 UART to the CSoC byte port.
// It also generates the CSoC clock and reset, and drives the debug LEDs and the hex display.
module csoc_test_top #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CSOC_CLK_DIV = 2,
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] leds,
  output logic [7:0] sseg,
  output logic [3:0] an,
  output logic       csoc_clk,
  output logic       csoc_rstn,
  output logic       csoc_test_se,
  output logic       csoc_test_tm,
  input  logic       csoc_uart_write,
  output logic       csoc_uart_read,
  input  logic [7:0] csoc_data_i,
  output logic [7:0] csoc_data_o
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF     = (BAUD_DIV / 2) < 1 ? 1 : BAUD_DIV / 2;
  localparam int DIVC     = CSOC_CLK_DIV < 1 ? 1 : CSOC_CLK_DIV;
  localparam int BW       = $clog2(BAUD_DIV + 1);
  localparam int DW       = $clog2(DIVC + 1);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;

  logic rx_s1_q, rx_s2_q, wr_s1_q, wr_s2_q, wr_d_q;
  logic [DW-1:0] div_q;
  logic csoc_clk_q, rstn_q;
  logic [3:0] rst_cnt_q;
  rx_st_t rx_st_q, rx_st_d;
  logic [BW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d, rxb_q, data_o_q;
  logic rx_good, ferr_q, ferr_d, pend_q, rd_q;
  logic [7:0] hold_q, txb_q;
  logic hold_full_q, ovf_q, tx_busy_q;
  logic [9:0] tx_sh_q;
  logic [BW-1:0] tx_cnt_q;
  logic [3:0] tx_n_q;
  logic [REFRESH_BITS+1:0] ref_q;
  logic [3:0] an_q;
  logic [7:0] sseg_q;

  logic tick, fall, cap, tx_last, done, load, accept;
  logic [1:0] dig;
  logic [3:0] nib;

  assign tick    = div_q == DW'(DIVC - 1);
  assign fall    = tick & csoc_clk_q;
  assign cap     = wr_s2_q & ~wr_d_q;
  assign tx_last = tx_cnt_q == BW'(BAUD_DIV - 1);
  // Reloading on the final stop-bit cycle keeps back-to-back frames gapless.
  assign done    = tx_busy_q & tx_last & (tx_n_q == 4'd9);
  assign load    = hold_full_q & (~tx_busy_q | done);
  assign accept  = ~hold_full_q | load;
  assign dig     = ref_q[REFRESH_BITS+1:REFRESH_BITS];
  assign nib     = dig == 2'd3 ? rxb_q[7:4] : dig == 2'd2 ? rxb_q[3:0] :
                   dig == 2'd1 ? txb_q[7:4] : txb_q[3:0];

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_good  = 1'b0;
    ferr_d   = ferr_q;
    case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) rx_st_d = R_START;
      end
      R_START: if (rx_cnt_q == BW'(HALF - 1)) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt_q == BW'(BAUD_DIV - 1)) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
      end
      R_STOP: if (rx_cnt_q == BW'(BAUD_DIV - 1)) begin
        rx_cnt_d = '0;
        rx_good  = rx_s2_q;
        ferr_d   = ferr_q | ~rx_s2_q;
        rx_st_d  = rx_s2_q ? R_IDLE : R_WAIT;
      end
      R_WAIT: begin
        rx_cnt_d = '0;
        if (rx_s2_q) rx_st_d = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {rx_s1_q, rx_s2_q, wr_s1_q, wr_s2_q, wr_d_q} <= 5'b11000;
      div_q       <= '0;
      csoc_clk_q  <= 1'b0;
      rstn_q      <= 1'b0;
      rst_cnt_q   <= '0;
      rx_st_q     <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rxb_q       <= '0;
      data_o_q    <= '0;
      ferr_q      <= 1'b0;
      pend_q      <= 1'b0;
      rd_q        <= 1'b0;
      hold_q      <= '0;
      txb_q       <= '0;
      hold_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_sh_q     <= '1;
      tx_cnt_q    <= '0;
      tx_n_q      <= '0;
      ref_q       <= '0;
      an_q        <= 4'hF;
      sseg_q      <= 8'hFF;
    end else begin
      {rx_s1_q, rx_s2_q, wr_s1_q, wr_s2_q, wr_d_q} <= {rx, rx_s1_q, csoc_uart_write, wr_s1_q, wr_s2_q};
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) csoc_clk_q <= ~csoc_clk_q;
      // Release on the 16th csoc_clk falling edge after reset.
      if (fall & ~rstn_q) begin
        rst_cnt_q <= rst_cnt_q + 1'b1;
        if (rst_cnt_q == 4'd15) rstn_q <= 1'b1;
      end
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      ferr_q   <= ferr_d;
      if (rx_good) begin
        data_o_q <= rx_sh_q;
        rxb_q    <= rx_sh_q;
      end
      pend_q <= rx_good ? 1'b1 : fall ? 1'b0 : pend_q;
      rd_q   <= fall ? pend_q : rd_q;
      if (cap & accept) begin
        hold_q <= csoc_data_i;
        txb_q  <= csoc_data_i;
      end
      hold_full_q <= (cap & accept) | (hold_full_q & ~load);
      if (cap & ~accept) ovf_q <= 1'b1;
      if (load) begin
        tx_sh_q   <= {1'b1, hold_q, 1'b0};
        tx_busy_q <= 1'b1;
        tx_cnt_q  <= '0;
        tx_n_q    <= '0;
      end else if (tx_busy_q) begin
        tx_cnt_q <= tx_last ? '0 : tx_cnt_q + 1'b1;
        if (tx_last) begin
          tx_sh_q <= {1'b1, tx_sh_q[9:1]};
          tx_n_q  <= tx_n_q + 1'b1;
          if (tx_n_q == 4'd9) tx_busy_q <= 1'b0;
        end
      end
      ref_q  <= ref_q + 1'b1;
      an_q   <= ~(4'b0001 << dig);
      sseg_q <= {1'b1, SEG[nib]};
    end
  end

  assign tx             = tx_sh_q[0];
  assign leds           = {ovf_q, ferr_q, tx_busy_q, rx_st_q != R_IDLE, 3'b000, rstn_q};
  assign sseg           = sseg_q;
  assign an             = an_q;
  assign csoc_clk       = csoc_clk_q;
  assign csoc_rstn      = rstn_q;
  assign csoc_test_se   = 1'b0;
  assign csoc_test_tm   = 1'b0;
  assign csoc_uart_read = rd_q;
  assign csoc_data_o    = data_o_q;
endmodule

// File: tb/tb_csoc_test_top.sv
// tb_csoc_test_top: randomized bench for csoc_test_top.
// Host UART, CSoC strobes and display are checked against a bench-side model.
module tb_csoc_test_top;
  localparam int CF = 1600, BR = 100, BD = CF / BR, CD = 2, RB = 4;

  logic clk = 1'b0, rst = 1'b0, rx = 1'b1, csoc_uart_write = 1'b0;
  logic [7:0] csoc_data_i = '0;
  logic tx, csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm, csoc_uart_read;
  logic [7:0] leds, sseg, csoc_data_o;
  logic [3:0] an;

  csoc_test_top #(.CLK_FREQ(CF), .BAUD(BR), .CSOC_CLK_DIV(CD), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .leds(leds), .sseg(sseg), .an(an),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
    .csoc_test_tm(csoc_test_tm), .csoc_uart_write(csoc_uart_write),
    .csoc_uart_read(csoc_uart_read), .csoc_data_i(csoc_data_i), .csoc_data_o(csoc_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // CSoC-side observer: counts read strobes, their width and data stability
  int rd_cnt = 0, rd_width = 0, rd_unstable = 0;
  logic [7:0] rd_data = '0;
  logic rd_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (csoc_uart_read === 1'b1) begin
      if (!rd_prev) begin
        rd_cnt++;
        rd_data = csoc_data_o;
        rd_width = 0;
      end
      rd_width++;
      if (csoc_data_o !== rd_data) rd_unstable++;
    end
    rd_prev = csoc_uart_read;
  end

  // Host-side UART receiver on tx
  int txq[$];
  int tx_start[$];
  int tx_ferr = 0, tt;
  logic [7:0] tb_b;
  initial forever begin
    @(negedge clk);
    if (rst && tx === 1'b0) begin
      tt = cyc;
      repeat (BD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        tb_b[i] = tx;
      end
      repeat (BD) @(negedge clk);
      if (tx !== 1'b1) tx_ferr++;
      txq.push_back(int'(tb_b));
      tx_start.push_back(tt);
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BD) @(negedge clk);
  endtask

  task automatic expect_rd(input string tag, input int prev, input logic [7:0] b);
    int k = 0;
    while (rd_cnt == prev && k < 40 * BD) begin @(negedge clk); k++; end
    k = 0;
    while (csoc_uart_read === 1'b1 && k < 100) begin @(negedge clk); k++; end
    check({tag, "_count"}, rd_cnt, prev + 1);
    check({tag, "_data"}, 32'(rd_data), 32'(b));
    check({tag, "_width"}, rd_width, 2 * CD);
    check({tag, "_stable"}, rd_unstable, 0);
  endtask

  task automatic check_digit(input int k, input logic [3:0] v);
    int w = 0;
    logic [3:0] want_an;
    want_an = ~(4'b0001 << k);
    while (an !== want_an && w < 8 * (1 << RB)) begin @(negedge clk); w++; end
    check($sformatf("an_digit%0d", k), 32'(an), 32'(want_an));
    check($sformatf("sseg_digit%0d", k), 32'(sseg), 32'(seg_tab[v]));
  endtask

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk);
    csoc_data_i = b;
    csoc_uart_write = 1'b1;
    repeat (4) @(negedge clk);
    csoc_uart_write = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_txq(input int n);
    int k = 0;
    while (txq.size() < n && k < 60 * BD) begin @(negedge clk); k++; end
    check("tx_frames_seen", txq.size() >= n, 1);
  endtask

  initial begin
    logic [7:0] b, b1, b2, b3;
    int t0, t1, k, prev;
    // Break condition: rx low from reset
    rst = 1'b0;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'hFF);
    check("rst_leds", 32'(leds), 0);
    check("rst_csoc_clk", 32'(csoc_clk), 0);
    check("rst_csoc_rstn", 32'(csoc_rstn), 0);
    check("rst_read", 32'(csoc_uart_read), 0);
    check("rst_data_o", 32'(csoc_data_o), 0);
    check("rst_se_tm", 32'({csoc_test_se, csoc_test_tm}), 0);
    rst = 1'b1;
    repeat (12 * BD) @(negedge clk);
    check("break_ferr", 32'(leds[6]), 1);
    check("break_no_read", rd_cnt, 0);
    check("break_data_o", 32'(csoc_data_o), 0);

    // Clean reset: CSoC reset release timing and clock period
    rst = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_leds", 32'(leds), 0);
    rst = 1'b1;
    t0 = cyc;
    k = 0;
    while (csoc_rstn !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    check("rstn_release_cycles", cyc - t0, 16 * 2 * CD);
    check("rstn_led", 32'(leds[0]), 1);
    k = 0;
    while (csoc_clk !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    while (csoc_clk !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    t0 = cyc;
    while (csoc_clk !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    while (csoc_clk !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("csoc_clk_period", cyc - t0, 2 * CD);

    // Host -> CSoC
    prev = rd_cnt;
    send_rx(8'hA5, 1'b1);
    expect_rd("rx_a5", prev, 8'hA5);
    check_digit(3, 4'hA);
    check_digit(2, 4'h5);
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      prev = rd_cnt;
      send_rx(b, 1'b1);
      expect_rd("rx_rand", prev, b);
      check_digit(3, b[7:4]);
      check_digit(2, b[3:0]);
    end
    prev = rd_cnt;
    send_rx(8'($urandom), 1'b0);
    repeat (8 * CD) @(negedge clk);
    check("ferr_no_read", rd_cnt, prev);
    check("ferr_led", 32'(leds[6]), 1);
    b = 8'($urandom);
    send_rx(b, 1'b1);
    expect_rd("rx_after_ferr", prev, b);

    // CSoC -> host
    tx_write(8'h3C);
    repeat (3 * BD) @(negedge clk);
    check("tx_busy_led", 32'(leds[5]), 1);
    wait_txq(1);
    check("tx_3c", txq[0], 32'h3C);
    repeat (2 * BD) @(negedge clk);
    check("tx_idle_led", 32'(leds[5]), 0);
    check_digit(1, 4'h3);
    check_digit(0, 4'hC);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      txq.delete();
      tx_start.delete();
      tx_write(b);
      wait_txq(1);
      check("tx_rand", txq[0], 32'(b));
      repeat (2 * BD) @(negedge clk);
    end
    check("tx_no_ovf_yet", 32'(leds[7]), 0);

    // Three writes within one frame: one in flight, one held, one dropped
    txq.delete();
    tx_start.delete();
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    b3 = 8'($urandom);
    tx_write(b1);
    tx_write(b2);
    tx_write(b3);
    wait_txq(2);
    repeat (14 * BD) @(negedge clk);
    check("ovf_frames", txq.size(), 2);
    check("ovf_first", txq[0], 32'(b1));
    check("ovf_second", txq[1], 32'(b2));
    t1 = tx_start[1] - tx_start[0];
    check("back_to_back_gap", t1, 10 * BD);
    check("ovf_led", 32'(leds[7]), 1);
    check("tx_stop_bits", tx_ferr, 0);

    // Reset in the middle of a frame of zeros
    tx_write(8'h00);
    repeat (3 * BD) @(negedge clk);
    check("mid_frame_tx_low", 32'(tx), 0);
    #2 rst = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 1);
    check("midrst_leds", 32'(leds), 0);
    check("midrst_rstn", 32'(csoc_rstn), 0);
    check("midrst_read", 32'(csoc_uart_read), 0);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/csoc_test_top.md
# csoc_test_top

FPGA-side test harness for the CSoC chip: bridges a host 8N1 UART to the CSoC byte-wide UART port, generates the CSoC clock and reset, and drives debug LEDs and a 4-digit seven-segment display. It sits at the FPGA top level between the board pins (rx/tx, LEDs, display) and the CSoC socket.

## Interface
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: UART bit rate; BAUD_DIV = CLK_FREQ/BAUD clk cycles per bit (integer division).
- CSOC_CLK_DIV, 2: csoc_clk toggles every CSOC_CLK_DIV clk cycles (minimum 1).
- REFRESH_BITS, 16: display digit dwell = 2^REFRESH_BITS clk cycles.

Ports:
- clk  in  1  system clock; the only clock; all flops on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  host UART receive, asynchronous; 2-flop synchronized.
- tx  out  1  host UART transmit; idles high.
- leds  out  8  debug status (see Operation).
- sseg  out  8  segments, active-low; bit7 = dp, bits6:0 = g..a.
- an  out  4  digit anodes, active-low, one-hot.
- csoc_clk  out  1  divided clock to CSoC.
- csoc_rstn  out  1  CSoC reset, active-low.
- csoc_test_se  out  1  scan enable, constant 0.
- csoc_test_tm  out  1  test mode, constant 0.
- csoc_uart_write  in  1  CSoC strobe: csoc_data_i valid; 2-flop synchronized.
- csoc_uart_read  out  1  strobe to CSoC: csoc_data_o valid.
- csoc_data_i  in  8  byte from CSoC to host.
- csoc_data_o  out  8  byte from host to CSoC.

## Operation
- Reset values: tx=1, csoc_clk=0, csoc_rstn=0, csoc_uart_read=0, csoc_data_o=0, leds=0, sseg=8'hFF, an=4'hF, csoc_test_se=0, csoc_test_tm=0; all internal state cleared.
- CSoC clock/reset: divider counts clk cycles, toggles csoc_clk every CSOC_CLK_DIV cycles. csoc_rstn released (1) on the first csoc_clk falling edge at least 16 csoc_clk periods after rst deasserts.
- RX path: idle until synchronized rx falls; re-check low at BAUD_DIV/2 (else back to idle, glitch); sample 8 data bits LSB-first at bit centers; check stop bit at center. Stop=1: byte latched into csoc_data_o and into display register RXB. Stop=0: byte discarded, leds[6] set (sticky), receiver waits for rx=1 before hunting next start bit.
- RX→CSoC strobe: after a good byte, csoc_uart_read asserts on the next csoc_clk falling edge and stays high exactly one csoc_clk period. csoc_data_o stable throughout. A new byte arriving while strobe pending overwrites csoc_data_o (CSoC too slow: loss accepted).
- TX path: rising edge of synchronized csoc_uart_write captures csoc_data_i (sampled on the same clk as edge detect) into one-byte holding register and display register TXB. Transmitter loads holding register when idle, sends start(0), 8 bits LSB-first, stop(1), each BAUD_DIV cycles. Capture while holding register already full: byte dropped, leds[7] set (sticky).
- leds: [7] tx overflow, [6] rx framing error, [5] tx busy, [4] rx busy, [3:1]=0, [0]=csoc_rstn. Sticky bits clear only on reset.
- Display: 2-bit digit counter advances every 2^REFRESH_BITS cycles; an[k]=0 for active digit k. Digits 3,2 = RXB[7:4],[3:0]; digits 1,0 = TXB[7:4],[3:0]; standard hex decode (0-F), dp off.

## Timing
- rx/csoc_uart_write input latency: 2 clk synchronizer + 1 edge-detect.
- csoc_data_o updates at stop-bit center (≈9.5 bit times after start edge + sync).
- tx start bit begins ≤2 clk after holding register loads when idle; frame = 10·BAUD_DIV clk.
- Back-to-back TX: next frame start bit immediately follows previous stop bit.
- Reset mid-frame: tx returns to 1 at once, frame abandoned, no strobe issued.

## Test plan
- Reset then idle: tx=1, an=4'hF during reset, csoc_rstn rises after 16 csoc_clk periods, csoc_clk period = 2·CSOC_CLK_DIV clk.
- rx held low from reset (break): leds[6]=1 after ~10 bit times, csoc_uart_read never asserts, csoc_data_o=0.
- Host sends 0xA5 on rx: csoc_data_o=8'hA5, one csoc_uart_read pulse of one csoc_clk period, digits 3,2 show "A5".
- CSoC pulses csoc_uart_write with csoc_data_i=0x3C: tx emits 0,0,0,1,1,1,1,0,0,1 per bit time; digits 1,0 show "3C"; leds[5] high during frame.
- Three write pulses within one frame: first two bytes transmitted in order, third dropped, leds[7]=1.
- Assert rst mid-transmit: tx=1 immediately, leds=0, csoc_rstn=0.
